// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC/OldPC/Instr/Data/instret and stalls the main FSM
// while instruction memory is slow, latching a sticky bus_error on fetch timeout.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCUpdate,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        IRWrite,
    input  logic [31:0] Result,
    input  logic [31:0] ReadData,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic [31:0] OldPC,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [31:0] Data,
    output logic        Stall,
    output logic        misaligned,
    output logic        bus_error,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WAIT  = 2'b01,
        ERROR = 2'b10
    } state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t      state_r, state_s;
    logic [7:0]  cnt_r, cnt_s;
    logic        pend_r, pend_s;
    logic        pc_write_s;
    logic        fetch_s;
    logic        pc_try_s;
    logic        pc_load_s;
    logic        mis_set_s;
    logic        err_set_s;
    logic        aligned_s;

    assign pc_write_s = PCUpdate | (Branch & Zero);
    assign aligned_s  = (Result[1:0] == 2'b00);
    assign pc_load_s  = pc_try_s & aligned_s;
    assign mis_set_s  = pc_try_s & ~aligned_s;
    assign op         = Instr[6:0];

    // State, wait counter and the PC write deferred across a stalled fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
        end
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        pend_s    = pend_r;
        fetch_s   = 1'b0;
        pc_try_s  = 1'b0;
        err_set_s = 1'b0;
        Stall     = 1'b0;
        case (state_r)
            IDLE: begin
                if (IRWrite && !mem_ready) begin
                    // PC write is held back so OldPC still sees the fetching PC.
                    state_s = WAIT;
                    cnt_s   = 8'd0;
                    pend_s  = pc_write_s;
                    Stall   = 1'b1;
                end else begin
                    fetch_s  = IRWrite;
                    pc_try_s = pc_write_s;
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    fetch_s  = 1'b1;
                    pc_try_s = pend_r;
                    pend_s   = 1'b0;
                    state_s  = IDLE;
                end else begin
                    Stall = 1'b1;
                    cnt_s = cnt_r + 8'd1;
                    if (cnt_s == TIMEOUT_C) begin
                        err_set_s = 1'b1;
                        state_s   = ERROR;
                    end else begin
                        state_s = WAIT;
                    end
                end
            end
            ERROR: begin
                Stall = 1'b1;
            end
            default: begin
                state_s = IDLE;
                Stall   = 1'b1;
            end
        endcase
    end

    // Architectural registers; Data is a plain one-cycle delay of ReadData.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC         <= RESET_PC;
            OldPC      <= 32'd0;
            Instr      <= 32'd0;
            Data       <= 32'd0;
            instret    <= 32'd0;
            misaligned <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            Data <= ReadData;
            if (fetch_s) begin
                Instr   <= ReadData;
                OldPC   <= PC;
                instret <= instret + 32'd1;
            end
            if (pc_load_s) begin
                PC <= Result;
            end
            if (mis_set_s) begin
                misaligned <= 1'b1;
            end
            if (err_set_s) begin
                bus_error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; expected values go through a scoreboard queue.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCUpdate, Branch, Zero, IRWrite, mem_ready;
    logic [31:0] Result, ReadData;
    logic [31:0] PC, OldPC, Instr, Data, instret;
    logic [6:0]  op;
    logic        Stall, misaligned, bus_error;

    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .PCUpdate(PCUpdate), .Branch(Branch), .Zero(Zero),
        .IRWrite(IRWrite), .Result(Result), .ReadData(ReadData), .mem_ready(mem_ready),
        .PC(PC), .OldPC(OldPC), .Instr(Instr), .op(op), .Data(Data), .Stall(Stall),
        .misaligned(misaligned), .bus_error(bus_error), .instret(instret)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; PCUpdate = 1'b0; Branch = 1'b0; Zero = 1'b0; IRWrite = 1'b0;
        mem_ready = 1'b0; Result = 32'd0; ReadData = 32'd0;
        #2;
        push(32'd0); chk("rst_pc", PC);
        push(32'd0); chk("rst_instr", Instr);
        push(32'd0); chk("rst_instret", instret);
        push(32'd0); chk("rst_stall", {31'd0, Stall});
        step();
        reset = 1'b0;

        // Fetch hit with simultaneous PC update: OldPC takes the pre-update PC.
        IRWrite = 1'b1; PCUpdate = 1'b1; Result = 32'd4; mem_ready = 1'b1; ReadData = 32'h0050_0093;
        #1;
        push(32'd0); chk("hit_stall", {31'd0, Stall});
        step();
        push(32'h0050_0093); chk("hit_instr", Instr);
        push(32'h13); chk("hit_op", {25'd0, op});
        push(32'd0); chk("hit_oldpc", OldPC);
        push(32'd4); chk("hit_pc", PC);
        push(32'd1); chk("hit_instret", instret);

        // Fetch miss for three cycles, then ready: deferred PC write lands on the ready edge.
        Result = 32'd8; mem_ready = 1'b0; ReadData = 32'hAABB_CCDD;
        for (int i = 0; i < 3; i++) begin
            #1;
            push(32'd1); chk("wait_stall", {31'd0, Stall});
            step();
            push(32'd4); chk("wait_pc", PC);
        end
        push(32'h0050_0093); chk("wait_instr_hold", Instr);
        push(32'hAABB_CCDD); chk("wait_data", Data);
        mem_ready = 1'b1; ReadData = 32'h00A0_0113;
        #1;
        push(32'd0); chk("ready_stall", {31'd0, Stall});
        step();
        push(32'd8); chk("ready_pc", PC);
        push(32'd4); chk("ready_oldpc", OldPC);
        push(32'h00A0_0113); chk("ready_instr", Instr);
        push(32'd2); chk("ready_instret", instret);

        // Branch not taken, then taken.
        IRWrite = 1'b0; PCUpdate = 1'b0; Branch = 1'b1; Zero = 1'b0; Result = 32'h40;
        step();
        push(32'd8); chk("bnt_pc", PC);
        Zero = 1'b1;
        step();
        push(32'h40); chk("bt_pc", PC);
        push(32'd0); chk("bt_misaligned", {31'd0, misaligned});

        // Misaligned branch target: PC holds, flag sticks.
        Result = 32'h0000_0102;
        step();
        push(32'h40); chk("mis_pc", PC);
        push(32'd1); chk("mis_flag", {31'd0, misaligned});
        Branch = 1'b0; Zero = 1'b0;
        step();
        push(32'd1); chk("mis_sticky", {31'd0, misaligned});

        // instret wrap.
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        IRWrite = 1'b1; mem_ready = 1'b1; ReadData = 32'h0000_0033;
        step();
        push(32'd0); chk("wrap_instret", instret);
        push(32'h40); chk("wrap_oldpc", OldPC);

        // Fetch timeout: 16 wait cycles to bus_error, then ERROR freezes everything but Data.
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 15; i++) step();
        push(32'd0); chk("to_before", {31'd0, bus_error});
        push(32'd1); chk("to_before_stall", {31'd0, Stall});
        step();
        push(32'd1); chk("to_bus_error", {31'd0, bus_error});
        push(32'd1); chk("to_stall", {31'd0, Stall});
        mem_ready = 1'b1; PCUpdate = 1'b1; Result = 32'h80; ReadData = 32'h1234_5678;
        step();
        push(32'd1); chk("err_stall", {31'd0, Stall});
        push(32'd0); chk("err_instret", instret);
        push(32'h0000_0033); chk("err_instr", Instr);
        push(32'h40); chk("err_pc", PC);
        push(32'h1234_5678); chk("err_data", Data);

        // Reset out of ERROR.
        reset = 1'b1;
        #1;
        push(32'd0); chk("rr_pc", PC);
        push(32'd0); chk("rr_stall", {31'd0, Stall});
        push(32'd0); chk("rr_bus_error", {31'd0, bus_error});
        push(32'd0); chk("rr_misaligned", {31'd0, misaligned});
        push(32'd0); chk("rr_instret", instret);
        step();
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, range 2..255, meaning the maximum cycles to wait for mem_ready before bus_error.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port PCUpdate, input, 1 bit: unconditional PC write request from the main FSM.
REQ-006 SHALL have port Branch, input, 1 bit: conditional PC write request from the main FSM.
REQ-007 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-008 SHALL have port IRWrite, input, 1 bit: instruction latch request from the main FSM.
REQ-009 SHALL have port Result, input, 32 bits: next-PC value from the result mux.
REQ-010 SHALL have port ReadData, input, 32 bits: memory read data.
REQ-011 SHALL have port mem_ready, input, 1 bit: memory read data valid this cycle.
REQ-012 SHALL have port PC, output, 32 bits: current program counter.
REQ-013 SHALL have port OldPC, output, 32 bits: PC of the instruction held in Instr.
REQ-014 SHALL have port Instr, output, 32 bits: instruction register.
REQ-015 SHALL have port op, output, 7 bits: Instr[6:0].
REQ-016 SHALL have port Data, output, 32 bits: memory data register (ReadData delayed one cycle).
REQ-017 SHALL have port Stall, output, 1 bit: freeze request to the main FSM.
REQ-018 SHALL have port misaligned, output, 1 bit: sticky flag, target not word-aligned.
REQ-019 SHALL have port bus_error, output, 1 bit: sticky flag, fetch timed out.
REQ-020 SHALL have port instret, output, 32 bits: count of instructions fetched.

Function
REQ-021 SHALL compute PCWrite = PCUpdate | (Branch & Zero).
REQ-022 SHALL implement states IDLE, WAIT, ERROR.
REQ-023 In IDLE, IRWrite & mem_ready SHALL in the same edge latch Instr<=ReadData, OldPC<=PC and increment instret; Stall stays 0.
REQ-024 In IDLE, IRWrite & !mem_ready SHALL move to WAIT, clear the wait counter and suppress PCWrite that cycle; Stall SHALL be combinationally 1 in that cycle.
REQ-025 In WAIT, Stall SHALL be 1 and PC, OldPC, Instr SHALL hold.
REQ-026 In WAIT with mem_ready=1, the unit SHALL latch Instr, OldPC and instret as in REQ-023, and perform a pending PCWrite from the stalled cycle using the current Result; it SHALL return to IDLE, Stall=0 that cycle.
REQ-027 In WAIT, the wait counter SHALL increment each cycle without mem_ready; on reaching TIMEOUT it SHALL set bus_error and enter ERROR.
REQ-028 ERROR SHALL be terminal until reset: Stall=1, no register updates except Data.
REQ-029 Outside WAIT/ERROR, PCWrite with Result[1:0]==2'b00 SHALL load PC<=Result on the edge.
REQ-030 PCWrite with Result[1:0]!=2'b00 SHALL leave PC unchanged and set misaligned (sticky).
REQ-031 Simultaneous IRWrite and PCWrite in IDLE with mem_ready SHALL capture OldPC as the pre-update PC.
REQ-032 Data SHALL load ReadData every cycle regardless of state.
REQ-033 instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-034 Branch & !Zero with PCUpdate=0 SHALL not modify PC.

Reset
REQ-035 On reset assertion, asynchronously: PC=RESET_PC, OldPC=0, Instr=0, Data=0, instret=0, misaligned=0, bus_error=0, state=IDLE, wait counter=0, Stall=0.
REQ-036 Reset mid-WAIT or in ERROR SHALL abandon the fetch and return to IDLE with REQ-035 values.

Verification
REQ-037 Reset, IRWrite=1, PCUpdate=1, Result=4, mem_ready=1, ReadData=32'h00500093 -> Instr=32'h00500093, op=7'h13, OldPC=0, PC=4, instret=1.
REQ-038 IRWrite=1, PCUpdate=1, Result=8, mem_ready=0 for 3 cycles then 1 -> Stall=1 for 3 cycles, PC=4 until the ready edge, then PC=8, OldPC=4.
REQ-039 Branch=1, Zero=1, Result=32'h0000_0102 -> PC unchanged, misaligned=1 and stays 1.
REQ-040 IRWrite=1, mem_ready held 0 with TIMEOUT=16 -> bus_error=1 after 16 wait cycles, Stall=1 persists; reset -> PC=RESET_PC, Stall=0, bus_error=0.
REQ-041 Branch=1, Zero=0, Result=32'h40 -> PC unchanged; then Zero=1 -> PC=32'h40.
REQ-042 Preload instret=32'hFFFF_FFFF via fetches (or force) then one fetch -> instret=0.
